// File: rtl/falcon_pkg.sv
// Shared constants, FSM state type and lane helper for the keygen SHAKE256
// squeeze path feeding the Gaussian sampler.
package falcon_pkg;

  localparam int unsigned LANE_W      = 64;
  localparam int unsigned RATE_WORDS  = 17;
  localparam int unsigned TOTAL_PAIRS = 1024;
  localparam int unsigned RATE_BITS   = RATE_WORDS * LANE_W;
  localparam int unsigned STATE_BITS  = 1600;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_WAIT
  } feed_state_e;

  // Out-of-range indices return zero instead of slicing past the rate portion.
  function automatic logic [LANE_W-1:0] lane_extract(input logic [RATE_BITS-1:0] blk,
                                                     input logic [4:0]           idx);
    logic [LANE_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < RATE_WORDS; i++) begin
      if (idx == 5'(i)) w = blk[LANE_W*i +: LANE_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/shake_gauss_feeder_pair_out_reg.sv
// 128-bit valid/ready output register; holds its contents while stalled.
module pair_out_reg
  import falcon_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_r1,
  input  logic [LANE_W-1:0] in_r2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_r1,
  output logic [LANE_W-1:0] out_r2
);

  logic                valid_q, valid_d;
  logic [2*LANE_W-1:0] data_q, data_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = {in_r1, in_r2};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_r1    = data_q[2*LANE_W-1:LANE_W];
  assign out_r2    = data_q[LANE_W-1:0];

endmodule

// File: rtl/shake_gauss_feeder.sv
// SHAKE256 squeeze-side word server: turns Keccak rate blocks into (r1, r2)
// word pairs for the Gaussian sampler, requesting permutations on demand.
module shake_gauss_feeder
  import falcon_pkg::*;
#(
  parameter int unsigned LOGN = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [STATE_BITS-1:0] state_in,
  output logic                  perm_req,
  input  logic                  perm_done,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [LANE_W-1:0]     r1,
  output logic [LANE_W-1:0]     r2,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned N_COEF    = 1 << LOGN;
  localparam int unsigned RUN_PAIRS = N_COEF * (TOTAL_PAIRS / N_COEF);
  localparam logic [10:0] RUN_PAIRS_W = 11'(RUN_PAIRS);
  localparam logic [10:0] LAST_PAIR   = 11'(RUN_PAIRS - 1);

  feed_state_e          state_q, state_d;
  logic [RATE_BITS-1:0] buf_q, buf_d;
  logic [4:0]           widx_q, widx_d;
  logic [LANE_W-1:0]    hold_q, hold_d;
  logic                 hold_v_q, hold_v_d;
  logic [10:0]          hs_cnt_q, hs_cnt_d;
  logic [10:0]          iss_cnt_q, iss_cnt_d;
  logic                 perm_req_q, perm_req_d;
  logic                 done_q, done_d;

  logic                 pv, p_ready;
  logic [LANE_W-1:0]    pr1, pr2;
  logic [4:0]           words_left;
  logic                 unused_state_hi;

  assign unused_state_hi = ^state_in[STATE_BITS-1:RATE_BITS];

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    widx_d     = widx_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    hs_cnt_d   = hs_cnt_q;
    iss_cnt_d  = iss_cnt_q;
    perm_req_d = 1'b0;
    done_d     = 1'b0;
    pv         = 1'b0;
    pr1        = '0;
    pr2        = '0;
    words_left = 5'(RATE_WORDS) - widx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d     = state_in[RATE_BITS-1:0];
          widx_d    = '0;
          hold_v_d  = 1'b0;
          hs_cnt_d  = '0;
          iss_cnt_d = '0;
          state_d   = S_SERVE;
        end
      end
      S_SERVE: begin
        if (iss_cnt_q != RUN_PAIRS_W) begin
          if (words_left >= 5'd2 || (hold_v_q && words_left != 5'd0)) begin
            if (p_ready) begin
              pv        = 1'b1;
              iss_cnt_d = iss_cnt_q + 11'd1;
              // A held lane from the previous block always leads the pair.
              if (hold_v_q) begin
                pr1      = hold_q;
                pr2      = lane_extract(buf_q, widx_q);
                widx_d   = widx_q + 5'd1;
                hold_v_d = 1'b0;
              end else begin
                pr1    = lane_extract(buf_q, widx_q);
                pr2    = lane_extract(buf_q, widx_q + 5'd1);
                widx_d = widx_q + 5'd2;
              end
            end
          end else begin
            if (words_left != 5'd0) begin
              hold_d   = lane_extract(buf_q, widx_q);
              hold_v_d = 1'b1;
            end
            perm_req_d = 1'b1;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (perm_done) begin
          buf_d   = state_in[RATE_BITS-1:0];
          widx_d  = '0;
          state_d = S_SERVE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (r_valid && r_ready) begin
      hs_cnt_d = hs_cnt_q + 11'd1;
      if (hs_cnt_q == LAST_PAIR) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      widx_q     <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      hs_cnt_q   <= '0;
      iss_cnt_q  <= '0;
      perm_req_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      widx_q     <= widx_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      hs_cnt_q   <= hs_cnt_d;
      iss_cnt_q  <= iss_cnt_d;
      perm_req_q <= perm_req_d;
      done_q     <= done_d;
    end
  end

  pair_out_reg u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pv),
    .in_ready  (p_ready),
    .in_r1     (pr1),
    .in_r2     (pr2),
    .out_valid (r_valid),
    .out_ready (r_ready),
    .out_r1    (r1),
    .out_r2    (r2)
  );

  assign perm_req = perm_req_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_shake_gauss_feeder.sv
// Bench for shake_gauss_feeder: Keccak responder model, word scoreboard,
// checkpoint table and hand-written reset/stall/perturbation sequences.
module tb_shake_gauss_feeder;

  logic          clk = 1'b0;
  logic          rst, start, perm_done, r_ready;
  logic [1599:0] state_in;
  logic          perm_req, r_valid, busy, done;
  logic [63:0]   r1, r2;

  shake_gauss_feeder #(.LOGN(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .state_in  (state_in),
    .perm_req  (perm_req),
    .perm_done (perm_done),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r1        (r1),
    .r2        (r2),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [63:0] r1;
    logic [63:0] r2;
  } vec_t;

  vec_t         tbl [8];
  int           checks, errors;
  int           cyc, pd_cyc, perm_timer, perm_delay;
  int           perm_cnt, hs_cnt, done_cnt;
  int unsigned  blk_next;
  bit           lat_chk;
  logic [63:0]  wq [$];
  logic [127:0] log_pairs [$];

  function automatic logic [63:0] wd(input int unsigned n, input int unsigned i);
    return {n[31:0], i[31:0]};
  endfunction

  function automatic logic [1599:0] mk_block(input int unsigned n);
    logic [1599:0] b;
    for (int i = 0; i < 25; i++) b[64*i +: 64] = wd(n, i);
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic present(input int unsigned n);
    state_in = mk_block(n);
    for (int i = 0; i < 17; i++) wq.push_back(wd(n, i));
  endtask

  task automatic edge_step();
    logic [63:0] e1, e2;
    if (r_valid === 1'b1 && r_ready === 1'b1) begin
      hs_cnt++;
      log_pairs.push_back({r1, r2});
      if (wq.size() < 2) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=0x%0h_%0h required=no pair", r1, r2);
      end else begin
        e1 = wq.pop_front();
        e2 = wq.pop_front();
        chk("pair_r1", r1, e1);
        chk("pair_r2", r2, e2);
      end
    end
    if (perm_req === 1'b1) begin
      perm_cnt++;
      chk("perm_req_while_outstanding", 64'(perm_timer > 0), 64'd0);
      perm_timer = perm_delay;
    end
    if (done === 1'b1) done_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    start     = 1'b0;
    perm_done = 1'b0;
    if (perm_timer > 0) begin
      perm_timer--;
      if (perm_timer == 0) begin
        present(blk_next);
        blk_next++;
        perm_done = 1'b1;
        pd_cyc    = cyc;
      end
    end
    if (lat_chk) begin
      if (cyc == pd_cyc + 1) chk("perm_lat_p1_valid", 64'(r_valid), 64'd0);
      if (cyc == pd_cyc + 2) chk("perm_lat_p2_valid", 64'(r_valid), 64'd1);
    end
  endtask

  task automatic begin_run(input int unsigned blk0);
    wq.delete();
    log_pairs.delete();
    hs_cnt   = 0;
    perm_cnt = 0;
    done_cnt = 0;
    blk_next = blk0 + 1;
    pd_cyc   = -10;
    present(blk0);
    start = 1'b1;
    edge_step();
  endtask

  task automatic end_checks(input string tag);
    repeat (6) edge_step();
    chk({tag, "_handshakes"}, 64'(hs_cnt), 64'd1024);
    chk({tag, "_perm_reqs"}, 64'(perm_cnt), 64'd120);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_valid_end"}, 64'(r_valid), 64'd0);
  endtask

  initial begin
    logic [63:0]  s1, s2;
    logic [127:0] p;
    int           guard;
    bit           stall_done, pert_start, pert_done, saw_valid;

    checks = 0;     errors = 0;     cyc = 0;
    rst = 1'b1;     start = 1'b0;   perm_done = 1'b0;  r_ready = 1'b0;
    state_in = '0;  perm_timer = 0; perm_delay = 24;   pd_cyc = -10;
    lat_chk = 1'b0; blk_next = 0;   hs_cnt = 0;        perm_cnt = 0;  done_cnt = 0;

    tbl[0] = '{0,    wd(0, 0),    wd(0, 1)};
    tbl[1] = '{3,    wd(0, 6),    wd(0, 7)};
    tbl[2] = '{7,    wd(0, 14),   wd(0, 15)};
    tbl[3] = '{8,    wd(0, 16),   wd(1, 0)};
    tbl[4] = '{9,    wd(1, 1),    wd(1, 2)};
    tbl[5] = '{16,   wd(1, 15),   wd(1, 16)};
    tbl[6] = '{25,   wd(2, 16),   wd(3, 0)};
    tbl[7] = '{1023, wd(120, 6),  wd(120, 7)};

    // Reset state
    repeat (3) edge_step();
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_r1", r1, 64'd0);
    chk("rst_r2", r2, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_perm_req", 64'(perm_req), 64'd0);
    rst = 1'b0;
    edge_step();

    // Run A: start latency, one 5-cycle stall, perm_done 24 cycles after each request
    r_ready = 1'b1;
    lat_chk = 1'b1;
    begin_run(0);
    chk("start_c1_busy", 64'(busy), 64'd1);
    chk("start_c1_valid", 64'(r_valid), 64'd0);
    edge_step();
    chk("start_c2_valid", 64'(r_valid), 64'd1);
    chk("start_c2_r1", r1, wd(0, 0));
    chk("start_c2_r2", r2, wd(0, 1));
    stall_done = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 20000) begin
      if (!stall_done && hs_cnt == 3 && r_valid) begin
        s1 = r1;
        s2 = r2;
        r_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          edge_step();
          chk("stall_valid", 64'(r_valid), 64'd1);
          chk("stall_r1", r1, s1);
          chk("stall_r2", r2, s2);
        end
        r_ready = 1'b1;
        stall_done = 1'b1;
      end
      edge_step();
      guard++;
    end
    chk("runA_finished", 64'(done_cnt != 0), 64'd1);
    lat_chk = 1'b0;
    end_checks("runA");
    for (int k = 0; k < 8; k++) begin
      if (tbl[k].idx < log_pairs.size()) begin
        p = log_pairs[tbl[k].idx];
        chk($sformatf("tbl_pair%0d_r1", tbl[k].idx), p[127:64], tbl[k].r1);
        chk($sformatf("tbl_pair%0d_r2", tbl[k].idx), p[63:0], tbl[k].r2);
      end else begin
        checks++;
        errors++;
        $display("FAIL tbl_pair%0d actual=missing required=present", tbl[k].idx);
      end
    end

    // Run B: stray start and stray perm_done during SERVE must not perturb anything
    begin_run(0);
    pert_start = 1'b0;
    pert_done  = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 20000) begin
      if (!pert_start && hs_cnt == 5) begin
        state_in = mk_block(99);
        start = 1'b1;
        pert_start = 1'b1;
      end
      if (!pert_done && hs_cnt == 20 && perm_timer == 0) begin
        state_in = mk_block(98);
        perm_done = 1'b1;
        pert_done = 1'b1;
      end
      edge_step();
      guard++;
    end
    chk("runB_finished", 64'(done_cnt != 0), 64'd1);
    end_checks("runB");

    // Reset while waiting for a permutation, then a late perm_done, then restart
    begin_run(0);
    guard = 0;
    while (perm_req !== 1'b1 && guard < 100) begin
      edge_step();
      guard++;
    end
    chk("rstwait_perm_seen", 64'(perm_req), 64'd1);
    edge_step();
    rst = 1'b1;
    edge_step();
    rst = 1'b0;
    perm_timer = 0;
    wq.delete();
    chk("rstwait_valid", 64'(r_valid), 64'd0);
    chk("rstwait_busy", 64'(busy), 64'd0);
    chk("rstwait_perm_req", 64'(perm_req), 64'd0);
    state_in = mk_block(7);
    perm_done = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      edge_step();
      if (r_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
    end
    chk("late_perm_done_ignored", 64'(saw_valid), 64'd0);
    begin_run(5);
    chk("restart_c1_valid", 64'(r_valid), 64'd0);
    edge_step();
    chk("restart_c2_valid", 64'(r_valid), 64'd1);
    chk("restart_r1", r1, wd(5, 0));
    chk("restart_r2", r2, wd(5, 1));
    rst = 1'b1;
    perm_timer = 0;
    edge_step();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
